// File: rtl/dnn_pkg.sv
// Shared constants for the output-layer datapath and the argmax hand-off.
package dnn_pkg;

   localparam int unsigned NUM_OUT_NEURONS    = 10;
   localparam int unsigned OUT_DATA_WIDTH     = 16;
   localparam int unsigned ARGMAX_SCAN_CYCLES = 10;

   // Observable packer condition, derived from {pend, gap_cnt != 0}.
   typedef enum logic [1:0] {
      PK_FILLING = 2'd0,
      PK_HOLDOFF = 2'd1,
      PK_PENDING = 2'd2
   } pack_state_e;

   // Counter width for a value range of n states, never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/holdoff_timer.sv
// Spacing timer: loads MIN_GAP-1 on a launch and counts down to zero.
// A new launch is only allowed while o_zero is high.
module holdoff_timer
   import dnn_pkg::*;
#(
   parameter int unsigned MIN_GAP = ARGMAX_SCAN_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_load,
   output logic o_zero
);

   localparam int unsigned GW = cnt_width(MIN_GAP);
   localparam logic [GW-1:0] LOAD_VAL = GW'(MIN_GAP - 1);

   logic [GW-1:0] gap_cnt_q;
   logic [GW-1:0] gap_cnt_d;

   // Next count: reload on launch, otherwise decrement until zero.
   always_comb begin
      gap_cnt_d = gap_cnt_q;
      if (i_load) begin
         gap_cnt_d = LOAD_VAL;
      end else if (gap_cnt_q != '0) begin
         gap_cnt_d = gap_cnt_q - GW'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         gap_cnt_q <= '0;
      end else begin
         gap_cnt_q <= gap_cnt_d;
      end
   end

   assign o_zero = (gap_cnt_q == '0);

endmodule

// File: rtl/result_vector_packer.sv
// Packs serial output-layer results into one flat vector for the argmax
// stage. A fill buffer and a pending buffer let the producer keep streaming
// while a completed vector waits out the argmax scan time.
module result_vector_packer
   import dnn_pkg::*;
#(
   parameter int unsigned NUM_ELEMS  = NUM_OUT_NEURONS,
   parameter int unsigned DATA_WIDTH = OUT_DATA_WIDTH,
   parameter int unsigned MIN_GAP    = ARGMAX_SCAN_CYCLES
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [DATA_WIDTH-1:0]           i_data,
   input  logic                            i_valid,
   output logic                            o_ready,
   output logic [NUM_ELEMS*DATA_WIDTH-1:0] o_data,
   output logic                            o_data_valid,
   output logic                            o_overrun
);

   localparam int unsigned CW = cnt_width(NUM_ELEMS);
   localparam int unsigned VW = NUM_ELEMS * DATA_WIDTH;
   localparam logic [CW-1:0] LAST = CW'(NUM_ELEMS - 1);

   logic [CW-1:0] fill_cnt_q, fill_cnt_d;
   logic [VW-1:0] fill_buf_q, fill_buf_d;
   logic [VW-1:0] pend_buf_q, pend_buf_d;
   logic          pend_q, pend_d;
   logic [VW-1:0] out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          overrun_q, overrun_d;

   pack_state_e   state;
   logic          gap_zero;
   logic          ready;
   logic          accept;
   logic          complete;
   logic          launch;

   holdoff_timer #(
      .MIN_GAP (MIN_GAP)
   ) u_holdoff (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_load (launch),
      .o_zero (gap_zero)
   );

   // Accept, pack, launch and pend decisions for this edge.
   always_comb begin
      state = pend_q ? PK_PENDING : (gap_zero ? PK_FILLING : PK_HOLDOFF);

      // Refusing the last slot while a vector is pending keeps completion
      // and pending launch from ever competing for the same edge.
      ready    = !(pend_q && (fill_cnt_q == LAST));
      accept   = i_valid && ready;
      complete = accept && (fill_cnt_q == LAST);

      fill_cnt_d  = fill_cnt_q;
      fill_buf_d  = fill_buf_q;
      pend_buf_d  = pend_buf_q;
      pend_d      = pend_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      launch      = 1'b0;
      overrun_d   = overrun_q | (i_valid && !ready);

      if (accept) begin
         fill_cnt_d = (fill_cnt_q == LAST) ? '0 : fill_cnt_q + CW'(1);
         for (int unsigned k = 0; k < NUM_ELEMS; k++) begin
            if (fill_cnt_q == CW'(k)) begin
               fill_buf_d[k*DATA_WIDTH +: DATA_WIDTH] = i_data;
            end
         end
      end

      // fill_buf_d already carries the final element on a completing beat.
      if (state == PK_PENDING && gap_zero) begin
         out_data_d  = pend_buf_q;
         out_valid_d = 1'b1;
         launch      = 1'b1;
         pend_d      = 1'b0;
      end else if (complete && state == PK_FILLING) begin
         out_data_d  = fill_buf_d;
         out_valid_d = 1'b1;
         launch      = 1'b1;
      end else if (complete) begin
         pend_buf_d = fill_buf_d;
         pend_d     = 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fill_cnt_q  <= '0;
         fill_buf_q  <= '0;
         pend_buf_q  <= '0;
         pend_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         fill_cnt_q  <= fill_cnt_d;
         fill_buf_q  <= fill_buf_d;
         pend_buf_q  <= pend_buf_d;
         pend_q      <= pend_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign o_ready      = ready;
   assign o_data       = out_data_q;
   assign o_data_valid = out_valid_q;
   assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_result_vector_packer.sv
// Directed bench: three packers share one stimulus stream, with scan gaps
// of 10 (default), 1 and 25 cycles.
module tb_result_vector_packer;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  data;
   logic         valid;

   logic         ready_a, dv_a, ovr_a;
   logic [159:0] data_a;
   logic         ready_b, dv_b, ovr_b;
   logic [159:0] data_b;
   logic         ready_c, dv_c, ovr_c;
   logic [159:0] data_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   result_vector_packer u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
      .o_ready(ready_a), .o_data(data_a), .o_data_valid(dv_a), .o_overrun(ovr_a)
   );

   result_vector_packer #(.NUM_ELEMS(10), .DATA_WIDTH(16), .MIN_GAP(1)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
      .o_ready(ready_b), .o_data(data_b), .o_data_valid(dv_b), .o_overrun(ovr_b)
   );

   result_vector_packer #(.NUM_ELEMS(10), .DATA_WIDTH(16), .MIN_GAP(25)) u_dut_c (
      .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid),
      .o_ready(ready_c), .o_data(data_c), .o_data_valid(dv_c), .o_overrun(ovr_c)
   );

   function automatic logic [15:0] slot(input logic [159:0] v, input int k);
      return v[k*16 +: 16];
   endfunction

   // Reference argmax: first index holding the largest element.
   function automatic int argmax(input logic [159:0] v);
      int best = 0;
      for (int k = 1; k < 10; k++) begin
         if (slot(v, k) > slot(v, best)) best = k;
      end
      return best;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; valid = 1'b1; data = 16'hFFFF;
      step(); step();
      rst = 1'b0; valid = 1'b0; data = 16'h0000;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (data_a !== '0)   begin errors++; $display("FAIL reset_data_a: got %h want 0", data_a); end
      checks++; if (dv_a !== 1'b0)   begin errors++; $display("FAIL reset_dv_a: got %b want 0", dv_a); end
      checks++; if (ovr_a !== 1'b0)  begin errors++; $display("FAIL reset_ovr_a: got %b want 0", ovr_a); end
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b want 1", ready_a); end
      checks++; if (dv_c !== 1'b0 || ovr_c !== 1'b0 || data_c !== '0)
         begin errors++; $display("FAIL reset_c: dv %b ovr %b data %h want 0", dv_c, ovr_c, data_c); end
   endtask

   task automatic test_single_vector();
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         data = 16'(k + 1); valid = 1'b1;
         checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL single_ready beat %0d: got %b want 1", k, ready_a); end
         step();
         if (k < 9) begin
            checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL single_early_pulse beat %0d: got %b want 0", k, dv_a); end
         end
      end
      valid = 1'b0;
      checks++; if (dv_a !== 1'b1) begin errors++; $display("FAIL single_pulse: got %b want 1", dv_a); end
      checks++; if (slot(data_a, 0) !== 16'h0001) begin errors++; $display("FAIL single_slot0: got %h want 0001", slot(data_a, 0)); end
      checks++; if (slot(data_a, 9) !== 16'h000A) begin errors++; $display("FAIL single_slot9: got %h want 000a", slot(data_a, 9)); end
      checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL single_ovr: got %b want 0", ovr_a); end
      step();
      checks++; if (dv_a !== 1'b0) begin errors++; $display("FAIL single_deassert: got %b want 0", dv_a); end
      checks++; if (slot(data_a, 9) !== 16'h000A) begin errors++; $display("FAIL single_hold: got %h want 000a", slot(data_a, 9)); end
   endtask

   task automatic test_back_to_back();
      int pa[$];
      int pb[$];
      logic [159:0] va[$];
      apply_reset();
      for (int e = 1; e <= 25; e++) begin
         valid = (e <= 20);
         data  = 16'h0200 + 16'(e - 1);
         if (e <= 20) begin
            checks++; if (ready_a !== 1'b1 || ready_b !== 1'b1)
               begin errors++; $display("FAIL b2b_ready edge %0d: got a=%b b=%b want 1", e, ready_a, ready_b); end
         end
         step();
         if (dv_a === 1'b1) begin pa.push_back(e); va.push_back(data_a); end
         if (dv_b === 1'b1) pb.push_back(e);
      end
      valid = 1'b0;
      checks++; if (pa.size() != 2) begin errors++; $display("FAIL b2b_count_a: got %0d want 2", pa.size()); end
      else begin
         checks++; if (pa[0] != 10 || pa[1] != 20) begin errors++; $display("FAIL b2b_edges_a: got %0d,%0d want 10,20", pa[0], pa[1]); end
         checks++; if (slot(va[1], 0) !== 16'h020A || slot(va[1], 9) !== 16'h0213)
            begin errors++; $display("FAIL b2b_vec2: got %h..%h want 020a..0213", slot(va[1], 0), slot(va[1], 9)); end
      end
      checks++; if (pb.size() != 2) begin errors++; $display("FAIL gap1_count: got %0d want 2", pb.size()); end
      else begin
         checks++; if (pb[0] != 10 || pb[1] != 20) begin errors++; $display("FAIL gap1_edges: got %0d,%0d want 10,20", pb[0], pb[1]); end
      end
      checks++; if (ovr_a !== 1'b0 || ovr_b !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got a=%b b=%b want 0", ovr_a, ovr_b); end
   endtask

   task automatic test_overrun();
      int pc[$];
      logic [159:0] vc[$];
      apply_reset();
      for (int e = 1; e <= 65; e++) begin
         valid = (e <= 30) || (e == 36);
         data  = (e <= 30) ? 16'h0300 + 16'(e - 1) : 16'h0ABC;
         if (e <= 30) begin
            checks++; if (ready_c !== (e != 30)) begin errors++; $display("FAIL ovr_ready edge %0d: got %b want %b", e, ready_c, (e != 30)); end
         end
         if (e == 36) begin
            checks++; if (ready_c !== 1'b1) begin errors++; $display("FAIL ovr_ready_after_launch: got %b want 1", ready_c); end
         end
         step();
         if (e == 29) begin
            checks++; if (ovr_c !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", ovr_c); end
         end
         if (dv_c === 1'b1) begin pc.push_back(e); vc.push_back(data_c); end
      end
      valid = 1'b0;
      checks++; if (ovr_c !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", ovr_c); end
      checks++; if (pc.size() != 3) begin errors++; $display("FAIL ovr_pulse_count: got %0d want 3", pc.size()); end
      else begin
         checks++; if (pc[0] != 10 || pc[1] != 35 || pc[2] != 60)
            begin errors++; $display("FAIL ovr_pulse_edges: got %0d,%0d,%0d want 10,35,60", pc[0], pc[1], pc[2]); end
         checks++; if (slot(vc[1], 0) !== 16'h030A || slot(vc[1], 9) !== 16'h0313)
            begin errors++; $display("FAIL ovr_pending_vec: got %h..%h want 030a..0313", slot(vc[1], 0), slot(vc[1], 9)); end
         checks++; if (slot(vc[2], 0) !== 16'h0314 || slot(vc[2], 8) !== 16'h031C || slot(vc[2], 9) !== 16'h0ABC)
            begin errors++; $display("FAIL ovr_third_vec: got %h %h %h want 0314 031c 0abc", slot(vc[2], 0), slot(vc[2], 8), slot(vc[2], 9)); end
      end
   endtask

   task automatic test_reset_mid_vector();
      int pa[$];
      logic [159:0] va[$];
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         data = 16'hDEA0 + 16'(k); valid = 1'b1; step();
      end
      rst = 1'b1; data = 16'hBEEF; step();
      rst = 1'b0; valid = 1'b0;
      checks++; if (dv_a !== 1'b0 || data_a !== '0) begin errors++; $display("FAIL mid_reset_out: dv %b data %h want 0", dv_a, data_a); end
      for (int e = 1; e <= 14; e++) begin
         valid = (e <= 10);
         data  = 16'h0100 + 16'(e - 1);
         step();
         if (dv_a === 1'b1) begin pa.push_back(e); va.push_back(data_a); end
      end
      valid = 1'b0;
      checks++; if (pa.size() != 1) begin errors++; $display("FAIL mid_pulse_count: got %0d want 1", pa.size()); end
      else begin
         checks++; if (pa[0] != 10) begin errors++; $display("FAIL mid_pulse_edge: got %0d want 10", pa[0]); end
         for (int k = 0; k < 10; k++) begin
            checks++; if (slot(va[0], k) !== 16'h0100 + 16'(k))
               begin errors++; $display("FAIL mid_slot%0d: got %h want %h", k, slot(va[0], k), 16'h0100 + 16'(k)); end
         end
      end
   endtask

   task automatic test_sparse_argmax();
      logic [15:0] vals [10];
      int pa[$];
      logic [159:0] va[$];
      int cyc = 0;
      vals = '{16'h0010, 16'h0200, 16'h1234, 16'h0003, 16'h7000,
               16'h0100, 16'h7FFF, 16'h7FFE, 16'h0000, 16'h0042};
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         for (int s = 0; s < 3; s++) begin
            valid = (s == 0);
            data  = vals[i];
            step(); cyc++;
            if (dv_a === 1'b1) begin pa.push_back(cyc); va.push_back(data_a); end
         end
      end
      valid = 1'b0;
      for (int s = 0; s < 5; s++) begin
         step(); cyc++;
         if (dv_a === 1'b1) begin pa.push_back(cyc); va.push_back(data_a); end
      end
      checks++; if (pa.size() != 1) begin errors++; $display("FAIL sparse_count: got %0d want 1", pa.size()); end
      else begin
         checks++; if (pa[0] != 28) begin errors++; $display("FAIL sparse_edge: got %0d want 28", pa[0]); end
         checks++; if (slot(va[0], 6) !== 16'h7FFF) begin errors++; $display("FAIL sparse_slot6: got %h want 7fff", slot(va[0], 6)); end
         checks++; if (argmax(va[0]) != 6) begin errors++; $display("FAIL sparse_argmax: got %0d want 6", argmax(va[0])); end
      end
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; data = '0;
      test_reset();
      test_single_vector();
      test_back_to_back();
      test_overrun();
      test_reset_mid_vector();
      test_sparse_argmax();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

endmodule
